multicycle_ctrl: RTL

Parametrised multi-cycle successor to the single-cycle main decoder. It sequences each instruction through IF/ID/EX/MEM/WB and drives the datapath control lines per state, not per opcode alone. A ready handshake stalls it on memory. It also counts retired instructions and supports run/halt from the testbench or host.

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM with memory ready handshake and retire counter.
// Optional illegal-opcode trap state and trap_o port enabled by defining ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               PC_write_o,
  output logic               IR_write_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               RegWrite_o,
  output logic               RegDst_o,
  output logic               ALUSrc_o,
  output logic               Branch_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   retired_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               trap_o
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP = 3'd6;
`endif

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_ADDI = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'b111);

  logic [2:0]         state_reg, state_next;
  logic [OP_W-1:0]    op_reg;
  logic [CNT_W-1:0]   retired_reg;
  logic               retire;
  logic               is_r, is_addi, is_slti, is_beq, is_j, is_lw, is_sw;
  logic               legal, uses_imm;
  logic [ALUOP_W-1:0] alu_class;

  always_comb begin
    is_r     = (op_reg == OP_R);
    is_addi  = (op_reg == OP_ADDI);
    is_slti  = (op_reg == OP_SLTI);
    is_beq   = (op_reg == OP_BEQ);
    is_j     = (op_reg == OP_J);
    is_lw    = (op_reg == OP_LW);
    is_sw    = (op_reg == OP_SW);
    legal    = is_r | is_addi | is_slti | is_beq | is_j | is_lw | is_sw;
    uses_imm = is_addi | is_slti | is_lw | is_sw;
    alu_class = ALU_ADD;
    if (is_r)    alu_class = ALU_FUNC;
    if (is_addi) alu_class = ALU_ADDI;
    if (is_slti) alu_class = ALU_SLT;
    if (is_beq)  alu_class = ALU_SUB;
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_IDLE: if (run_i) state_next = S_IF;
      S_IF:   if (mem_ready_i) state_next = S_ID;
      S_ID: begin
        if (legal) state_next = S_EX;
`ifdef ILLEGAL_TRAP_EN
        else state_next = S_TRAP;
`else
        else retire = 1'b1;
`endif
      end
      S_EX: begin
        if (is_r | is_addi | is_slti) state_next = S_WB;
        else if (is_lw | is_sw) state_next = S_MEM;
        else retire = 1'b1;
      end
      S_MEM: begin
        if (mem_ready_i) begin
          if (is_lw) state_next = S_WB;
          else retire = 1'b1;
        end
      end
      S_WB: retire = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_IDLE;
    endcase
    // run_i only matters at instruction boundaries, so a drop never aborts work in flight
    if (retire) state_next = run_i ? S_IF : S_IDLE;
  end

  always_comb begin
    PC_write_o = 1'b0;
    IR_write_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    RegDst_o   = 1'b0;
    ALUSrc_o   = 1'b0;
    Branch_o   = 1'b0;
    ALU_op_o   = ALU_ADD;
    case (state_reg)
      S_IF: begin
        MemRead_o  = 1'b1;
        IR_write_o = mem_ready_i;
        PC_write_o = mem_ready_i;
      end
      S_EX: begin
        ALU_op_o   = alu_class;
        ALUSrc_o   = uses_imm;
        Branch_o   = is_beq;
        PC_write_o = is_j;
      end
      S_MEM: begin
        // address operands stay selected while the access waits on ready
        ALU_op_o   = alu_class;
        ALUSrc_o   = uses_imm;
        MemRead_o  = is_lw;
        MemWrite_o = is_sw;
      end
      S_WB: begin
        ALU_op_o   = alu_class;
        ALUSrc_o   = uses_imm;
        RegWrite_o = 1'b1;
        RegDst_o   = is_r;
        MemtoReg_o = is_lw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IF && mem_ready_i) op_reg <= instr_op_i;
      if (retire) retired_reg <= retired_reg + 1'b1;
    end
  end

  assign state_o   = state_reg;
  assign retired_o = retired_reg;
`ifdef ILLEGAL_TRAP_EN
  assign trap_o    = (state_reg == S_TRAP);
`endif

endmodule
